cby_cfg_loader: RTL

//  Configuration-chain controller for one Y-channel connection-block tile (32-track chany bottom/top).

---
 rtl/cby_cfg_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cby_cfg_loader.sv
`default_nettype none
// ============================================================================
// cby_cfg_loader : LSB-first serialiser of bitstream words into a CBY tile
// configuration chain. Optional CRC-16/CCITT check with CBY_CFG_CRC_EN.
// Revision: 1.0
// ============================================================================
module cby_cfg_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + DATA_W + 1);
  localparam logic [CW-1:0] C_CHAIN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] C_DW    = CW'(DATA_W);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     sbits;    // valid bits still held in sreg
  logic [CW-1:0]     rem;      // chain bits still to shift
  logic [CW-1:0]     unalloc;  // chain bits not yet covered by an accepted word
  logic [CW-1:0]     take;
  logic              last_head;
  logic              shift, room, accept, load_go, last_bit;

`ifdef CBY_CFG_CRC_EN
  localparam int CRC_WORDS = (16 + DATA_W - 1) / DATA_W;
  localparam int EW        = CRC_WORDS * DATA_W;
  localparam int IW        = $clog2(CRC_WORDS + 1);

  logic [15:0]   crc, crc_nxt;
  logic [EW-1:0] exp_crc, exp_nxt;
  logic [IW-1:0] crc_idx;
  logic          crc_last, crc_ok;
`endif

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    shift     = (state == S_LOAD) && (sbits != '0);
    room      = (sbits == '0) || ((sbits == C_ONE) && shift);
    take      = (unalloc >= C_DW) ? C_DW : unalloc;
    load_go   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    last_bit  = shift && (rem == C_ONE);
    cfg_ready = (state == S_LOAD) && room && (unalloc != '0);
`ifdef CBY_CFG_CRC_EN
    if (state == S_CHECK) cfg_ready = 1'b1;
`endif
    accept        = cfg_valid && cfg_ready;
    ccff_shift_en = shift;
    ccff_head     = shift ? sreg[0] : last_head;
    busy          = (state == S_LOAD) || (state == S_CHECK);
    done          = (state == S_DONE);
`ifdef CBY_CFG_CRC_EN
    err           = (state == S_ERR);
`else
    err           = 1'b0;
`endif

    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LOAD;
`ifdef CBY_CFG_CRC_EN
      S_LOAD:  if (last_bit) state_nxt = S_CHECK;
      S_CHECK: if (crc_last) state_nxt = crc_ok ? S_DONE : S_ERR;
`else
      S_LOAD:  if (last_bit) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg      <= '0;
      sbits     <= '0;
      rem       <= '0;
      unalloc   <= '0;
      last_head <= 1'b0;
    end else if (load_go) begin
      sreg      <= '0;
      sbits     <= '0;
      rem       <= C_CHAIN;
      unalloc   <= C_CHAIN;
      last_head <= 1'b0;
    end else begin
      // A new word may land in the same cycle the previous word's last bit leaves
      if (accept && (state == S_LOAD)) begin
        sreg    <= cfg_data;
        sbits   <= take;
        unalloc <= unalloc - take;
      end else if (shift) begin
        sreg  <= (sbits == C_ONE) ? '0 : (sreg >> 1);
        sbits <= sbits - C_ONE;
      end
      if (shift) begin
        rem       <= rem - C_ONE;
        last_head <= sreg[0];
      end
    end
  end

`ifdef CBY_CFG_CRC_EN
  always_comb begin
    crc_nxt  = {crc[14:0], 1'b0} ^ ((crc[15] ^ sreg[0]) ? 16'h1021 : 16'h0000);
    exp_nxt  = exp_crc | (EW'(cfg_data) << (crc_idx * DATA_W));
    crc_last = accept && (state == S_CHECK) && (crc_idx == IW'(CRC_WORDS - 1));
    crc_ok   = (exp_nxt[15:0] == crc);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      crc     <= 16'hFFFF;
      exp_crc <= '0;
      crc_idx <= '0;
    end else if (load_go) begin
      crc     <= 16'hFFFF;
      exp_crc <= '0;
      crc_idx <= '0;
    end else begin
      if (shift) crc <= crc_nxt;
      if (accept && (state == S_CHECK)) begin
        exp_crc <= exp_nxt;
        crc_idx <= crc_idx + IW'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire
